// File: rtl/tlk2711_pkg.sv
// Shared constants and types for the TLK2711 TX pattern generator (and the future RX checker).
//   Byte constants : K28_5, K27_7, K29_7, D5_6
//   Control words  : IDLE_WORD, SOF_WORD, EOF_WORD (upper byte D5.6, lower byte K-char)
//   Types          : mode_e (payload mode), state_e (frame FSM state)
//   Helper         : lfsr_step, one step of the x^16+x^15+x^13+x^4+1 Fibonacci LFSR
package tlk2711_pkg;

    localparam int unsigned WORD_W = 16;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] D5_6  = 8'hC5;

    localparam logic [WORD_W-1:0] IDLE_WORD = {D5_6, K28_5};
    localparam logic [WORD_W-1:0] SOF_WORD  = {D5_6, K27_7};
    localparam logic [WORD_W-1:0] EOF_WORD  = {D5_6, K29_7};

    localparam logic [WORD_W-1:0] PRBS_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        MODE_COUNTER = 3'd0,
        MODE_PRBS    = 3'd1,
        MODE_FIXED   = 3'd2,
        MODE_WALK    = 3'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SOF     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_EOF     = 3'd3,
        ST_GAP     = 3'd4
    } state_e;

    // Shift left, feedback from taps 16,15,13,4 (bits 15,14,12,3)
    function automatic logic [WORD_W-1:0] lfsr_step(input logic [WORD_W-1:0] s);
        return {s[WORD_W-2:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    endfunction

endpackage

// File: rtl/tlk2711_lane_payload.sv
// Per-lane payload word source: mode mux, PRBS LFSR and lane counter offset.
//   clk, rstn    : link clock, async active-low reset
//   mode_i       : payload mode latched at SOF (4-7 behave as counter)
//   w_i          : payload word index within the frame
//   seed_load_i  : reseed the LFSR with PRBS_SEED ^ LANE
//   advance_i    : step the LFSR by one word
//   word_c       : combinational payload word for index w_i
module tlk2711_lane_payload
    import tlk2711_pkg::*;
#(
    parameter int unsigned LANE          = 0,
    parameter logic [15:0] FIXED_PATTERN = 16'hA55A
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [2:0]        mode_i,
    input  logic [WORD_W-1:0] w_i,
    input  logic              seed_load_i,
    input  logic              advance_i,
    output logic [WORD_W-1:0] word_c
);

    localparam logic [WORD_W-1:0] LANE_SEED = PRBS_SEED ^ WORD_W'(LANE);

    logic [WORD_W-1:0] lfsr_q;
    logic [WORD_W-1:0] lane_idx_c;

    // LFSR: the word shown is the current state; it advances after each payload word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= LANE_SEED;
        end else if (seed_load_i) begin
            lfsr_q <= LANE_SEED;
        end else if (advance_i) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    // Mode mux
    always_comb begin
        lane_idx_c = w_i + WORD_W'(LANE);
        word_c     = lane_idx_c;
        case (mode_i)
            MODE_PRBS:  word_c = lfsr_q;
            MODE_FIXED: word_c = FIXED_PATTERN;
            MODE_WALK:  word_c = WORD_W'(1) << lane_idx_c[3:0];
            default:    word_c = lane_idx_c;
        endcase
    end

endmodule

// File: rtl/tlk2711_tx_pattern_gen.sv
// Multi-lane TLK2711 TX test-pattern generator: IDLE / SOF / payload / EOF / gap framing.
//   clk, rstn    : link TX clock, async active-low reset
//   i_start      : level, rising edge starts generation (ignored while busy)
//   i_stop       : level, rising edge requests stop after the current frame
//   i_mode       : payload mode, sampled at each SOF
//   o_txd        : lane l on [16l+15:16l]
//   o_tkmsb      : upper-byte K flag per lane (always 0)
//   o_tklsb      : lower-byte K flag per lane (1 on control words)
//   o_busy       : high from start until stop completes
//   o_stop_ack   : one-cycle pulse when stop completes
//   o_frame_cnt  : EOFs sent since the last start (wraps)
module tlk2711_tx_pattern_gen
    import tlk2711_pkg::*;
#(
    parameter int unsigned NUM_LANES     = 1,
    parameter int unsigned FRAME_LEN     = 256,
    parameter int unsigned GAP_LEN       = 4,
    parameter logic [15:0] FIXED_PATTERN = 16'hA55A
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        i_start,
    input  logic                        i_stop,
    input  logic [2:0]                  i_mode,
    output logic [WORD_W*NUM_LANES-1:0] o_txd,
    output logic [NUM_LANES-1:0]        o_tkmsb,
    output logic [NUM_LANES-1:0]        o_tklsb,
    output logic                        o_busy,
    output logic                        o_stop_ack,
    output logic [31:0]                 o_frame_cnt
);

    localparam int unsigned CNT_W = WORD_W;
    localparam int unsigned TXD_W = WORD_W * NUM_LANES;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'(GAP_LEN - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         mode_q, mode_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic               pend_q, pend_d;
    logic [31:0]        fcnt_q, fcnt_d;
    logic               start_q, stop_q;
    logic [TXD_W-1:0]   txd_q, txd_d;
    logic [NUM_LANES-1:0] tklsb_q, tklsb_d;

    logic               start_edge_c, stop_edge_c;
    logic               seed_load_c, advance_c;
    logic [TXD_W-1:0]   payload_c;

    assign start_edge_c = i_start & ~start_q;
    assign stop_edge_c  = i_stop & ~stop_q;

    // One payload source per lane
    for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane
        tlk2711_lane_payload #(
            .LANE          (gl),
            .FIXED_PATTERN (FIXED_PATTERN)
        ) u_payload (
            .clk         (clk),
            .rstn        (rstn),
            .mode_i      (mode_q),
            .w_i         (cnt_q),
            .seed_load_i (seed_load_c),
            .advance_i   (advance_c),
            .word_c      (payload_c[WORD_W*gl +: WORD_W])
        );
    end

    // State, counters, edge detectors and output register stage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_COUNTER;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
            fcnt_q  <= '0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            txd_q   <= {NUM_LANES{IDLE_WORD}};
            tklsb_q <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
            fcnt_q  <= fcnt_d;
            start_q <= i_start;
            stop_q  <= i_stop;
            txd_q   <= txd_d;
            tklsb_q <= tklsb_d;
        end
    end

    // Next state and next output word; pins show the current state one cycle later
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        busy_d      = busy_q;
        ack_d       = 1'b0;
        pend_d      = pend_q | stop_edge_c;
        fcnt_d      = fcnt_q;
        seed_load_c = 1'b0;
        advance_c   = 1'b0;
        txd_d       = {NUM_LANES{IDLE_WORD}};
        tklsb_d     = '1;

        case (state_q)
            ST_IDLE: begin
                // Stop has priority: covers both the post-frame entry and a stop edge while idle
                pend_d = 1'b0;
                if (pend_q || stop_edge_c) begin
                    ack_d  = 1'b1;
                    busy_d = 1'b0;
                end else if (start_edge_c) begin
                    busy_d  = 1'b1;
                    fcnt_d  = '0;
                    state_d = ST_SOF;
                end
            end
            ST_SOF: begin
                txd_d       = {NUM_LANES{SOF_WORD}};
                mode_d      = i_mode;
                cnt_d       = '0;
                seed_load_c = 1'b1;
                state_d     = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                txd_d     = payload_c;
                tklsb_d   = '0;
                advance_c = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_WORD) begin
                    state_d = ST_EOF;
                end
            end
            ST_EOF: begin
                txd_d   = {NUM_LANES{EOF_WORD}};
                fcnt_d  = fcnt_q + 32'd1;
                cnt_d   = '0;
                state_d = pend_d ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_GAP) begin
                    state_d = pend_d ? ST_IDLE : ST_SOF;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_txd       = txd_q;
    assign o_tkmsb     = '0;
    assign o_tklsb     = tklsb_q;
    assign o_busy      = busy_q;
    assign o_stop_ack  = ack_q;
    assign o_frame_cnt = fcnt_q;

endmodule

// File: tb/tb_tlk2711_tx_pattern_gen.sv
// Self-checking bench for tlk2711_tx_pattern_gen (2 lanes, 4-word frames, 2-word gap).
module tb_tlk2711_tx_pattern_gen;

    localparam int NL = 2;
    localparam int FL = 4;
    localparam int GL = 2;
    localparam logic [15:0] W_IDLE = 16'hC5BC;
    localparam logic [15:0] W_SOF  = 16'hC5FB;
    localparam logic [15:0] W_EOF  = 16'hC5FD;
    localparam logic [15:0] FIXED  = 16'hA55A;
    localparam logic [31:0] II = {W_IDLE, W_IDLE};
    localparam logic [31:0] SS = {W_SOF, W_SOF};
    localparam logic [31:0] EE = {W_EOF, W_EOF};

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_start, i_stop;
    logic [2:0]    i_mode;
    logic [31:0]   o_txd;
    logic [NL-1:0] o_tkmsb, o_tklsb;
    logic          o_busy, o_stop_ack;
    logic [31:0]   o_frame_cnt;

    always #5 clk = ~clk;

    tlk2711_tx_pattern_gen #(
        .NUM_LANES     (NL),
        .FRAME_LEN     (FL),
        .GAP_LEN       (GL),
        .FIXED_PATTERN (FIXED)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_mode      (i_mode),
        .o_txd       (o_txd),
        .o_tkmsb     (o_tkmsb),
        .o_tklsb     (o_tklsb),
        .o_busy      (o_busy),
        .o_stop_ack  (o_stop_ack),
        .o_frame_cnt (o_frame_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: position within the frame schedule SOF, FL payload, EOF, GL gap
    bit            m_active, m_pend, m_busy, m_ack, m_prev_start, m_prev_stop;
    int            m_pos;
    logic [2:0]    m_mode;
    logic [31:0]   m_fcnt;
    logic [15:0]   m_txd  [NL];
    logic [15:0]   m_prbs [NL];
    logic [NL-1:0] m_lsb;

    typedef struct {
        logic        start;
        logic        stop;
        logic [2:0]  mode;
        logic [31:0] txd;
        logic [1:0]  lsb;
        logic        busy;
        logic        ack;
        logic [31:0] fcnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] prbs_next(input logic [15:0] s);
        int   taps[4];
        logic fb;
        taps = '{16, 15, 13, 4};
        fb = 1'b0;
        foreach (taps[k]) fb ^= s[taps[k] - 1];
        return {s[14:0], fb};
    endfunction

    function automatic logic [15:0] model_payload(input int l, input int w);
        logic [15:0] one;
        one = 16'h0001;
        case (m_mode)
            3'd1:    return m_prbs[l];
            3'd2:    return FIXED;
            3'd3:    return one << ((w + l) % 16);
            default: return 16'(w + l);
        endcase
    endfunction

    task automatic set_ctl(input logic [15:0] w);
        for (int l = 0; l < NL; l++) m_txd[l] = w;
        m_lsb = '1;
    endtask

    task automatic model_reset();
        m_active = 0; m_pend = 0; m_busy = 0; m_ack = 0;
        m_prev_start = 0; m_prev_stop = 0;
        m_pos = 0; m_mode = 3'd0; m_fcnt = 32'd0;
        for (int l = 0; l < NL; l++) m_prbs[l] = 16'hACE1 ^ 16'(l);
        set_ctl(W_IDLE);
    endtask

    // Advance the model by one clock edge using the inputs presented before that edge
    task automatic model_step();
        bit se, st;
        se = i_start && !m_prev_start;
        st = i_stop && !m_prev_stop;
        m_prev_start = i_start;
        m_prev_stop  = i_stop;
        m_ack = 0;
        if (!m_active) begin
            set_ctl(W_IDLE);
            if (m_pend || st) begin
                m_ack = 1; m_busy = 0; m_pend = 0;
            end else if (se) begin
                m_busy = 1; m_fcnt = 32'd0; m_active = 1; m_pos = 0;
            end
        end else begin
            if (st) m_pend = 1;
            if (m_pos == 0) begin
                set_ctl(W_SOF);
                m_mode = i_mode;
                for (int l = 0; l < NL; l++) m_prbs[l] = 16'hACE1 ^ 16'(l);
            end else if (m_pos <= FL) begin
                for (int l = 0; l < NL; l++) begin
                    m_txd[l]  = model_payload(l, m_pos - 1);
                    m_prbs[l] = prbs_next(m_prbs[l]);
                end
                m_lsb = '0;
            end else if (m_pos == FL + 1) begin
                set_ctl(W_EOF);
                m_fcnt = m_fcnt + 32'd1;
            end else begin
                set_ctl(W_IDLE);
            end
            m_pos++;
            if (m_pos == FL + 2 && m_pend) begin
                m_active = 0;
            end else if (m_pos == FL + 2 + GL) begin
                m_pos = 0;
                if (m_pend) m_active = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        chk("model_pins", 64'({o_txd, o_tklsb, o_tkmsb, o_busy, o_stop_ack}),
            64'({m_txd[1], m_txd[0], m_lsb, 2'b00, m_busy, m_ack}));
        chk("model_fcnt", 64'(o_frame_cnt), 64'(m_fcnt));
    endtask

    task automatic tick(input logic s, input logic p, input logic [2:0] m);
        @(negedge clk);
        i_start = s; i_stop = p; i_mode = m;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic run_until_word(input logic [15:0] w, input int budget, input string name);
        int n;
        n = 0;
        while (o_txd[15:0] !== w && n < budget) begin
            tick(i_start, i_stop, i_mode);
            n++;
        end
        chk(name, 64'(o_txd[15:0]), 64'(w));
    endtask

    task automatic add(input logic s, input logic p, input logic [31:0] txd, input logic [1:0] lsb,
                       input logic busy, input logic ack, input logic [31:0] fcnt);
        vec_t v;
        v.start = s; v.stop = p; v.mode = 3'd0; v.txd = txd; v.lsb = lsb;
        v.busy = busy; v.ack = ack; v.fcnt = fcnt;
        vecs.push_back(v);
    endtask

    initial begin
        logic s, p;

        // Two frames of counter payload, stop in frame 3, then idle-state stop handling
        add(1, 0, II, 2'b11, 1, 0, 0);
        add(1, 0, SS, 2'b11, 1, 0, 0);
        add(1, 0, 32'h0001_0000, 2'b00, 1, 0, 0);
        add(1, 0, 32'h0002_0001, 2'b00, 1, 0, 0);
        add(1, 0, 32'h0003_0002, 2'b00, 1, 0, 0);
        add(1, 0, 32'h0004_0003, 2'b00, 1, 0, 0);
        add(1, 0, EE, 2'b11, 1, 0, 1);
        add(1, 0, II, 2'b11, 1, 0, 1);
        add(1, 0, II, 2'b11, 1, 0, 1);
        add(1, 0, SS, 2'b11, 1, 0, 1);
        add(1, 0, 32'h0001_0000, 2'b00, 1, 0, 1);
        add(1, 0, 32'h0002_0001, 2'b00, 1, 0, 1);
        add(1, 0, 32'h0003_0002, 2'b00, 1, 0, 1);
        add(1, 0, 32'h0004_0003, 2'b00, 1, 0, 1);
        add(1, 0, EE, 2'b11, 1, 0, 2);
        add(1, 0, II, 2'b11, 1, 0, 2);
        add(1, 0, II, 2'b11, 1, 0, 2);
        add(1, 0, SS, 2'b11, 1, 0, 2);
        add(1, 0, 32'h0001_0000, 2'b00, 1, 0, 2);
        add(1, 1, 32'h0002_0001, 2'b00, 1, 0, 2);
        add(1, 1, 32'h0003_0002, 2'b00, 1, 0, 2);
        add(1, 1, 32'h0004_0003, 2'b00, 1, 0, 2);
        add(1, 1, EE, 2'b11, 1, 0, 3);
        add(1, 1, II, 2'b11, 0, 1, 3);
        add(1, 1, II, 2'b11, 0, 0, 3);
        add(1, 0, II, 2'b11, 0, 0, 3);
        add(1, 1, II, 2'b11, 0, 1, 3);
        add(1, 1, II, 2'b11, 0, 0, 3);
        add(0, 0, II, 2'b11, 0, 0, 3);
        add(1, 1, II, 2'b11, 0, 1, 3);
        add(1, 1, II, 2'b11, 0, 0, 3);
        add(1, 1, II, 2'b11, 0, 0, 3);

        rstn = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_mode = 3'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pins", 64'({o_txd, o_tklsb, o_tkmsb, o_busy, o_stop_ack}),
            64'({II, 2'b11, 2'b00, 1'b0, 1'b0}));
        chk("reset_fcnt", 64'(o_frame_cnt), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick(0, 0, 0);
        tick(0, 0, 0);

        foreach (vecs[i]) begin
            tick(vecs[i].start, vecs[i].stop, vecs[i].mode);
            chk($sformatf("vec%0d_pins", i), 64'({o_txd, o_tklsb, o_busy, o_stop_ack}),
                64'({vecs[i].txd, vecs[i].lsb, vecs[i].busy, vecs[i].ack}));
            chk($sformatf("vec%0d_fcnt", i), 64'(o_frame_cnt), 64'(vecs[i].fcnt));
        end

        // PRBS payload and reseed at every SOF
        tick(0, 0, 1);
        tick(1, 0, 1);
        chk("start_busy", 64'(o_busy), 64'd1);
        chk("start_fcnt_clear", 64'(o_frame_cnt), 64'd0);
        run_until_word(W_SOF, 5, "sof_prbs1");
        tick(1, 0, 1);
        chk("prbs_first", 64'(o_txd), 64'({16'hACE0, 16'hACE1}));
        run_until_word(W_SOF, 20, "sof_prbs2");
        tick(1, 0, 1);
        chk("prbs_reseed", 64'(o_txd), 64'({16'hACE0, 16'hACE1}));

        // Start edge while busy is ignored
        tick(0, 0, 1);
        tick(1, 0, 1);
        chk("start_ignored_busy", 64'(o_busy), 64'd1);
        chk("start_ignored_fcnt", 64'(o_frame_cnt), 64'd1);

        // Mode change mid-frame takes effect at the next SOF only
        tick(1, 0, 0);
        run_until_word(W_SOF, 20, "sof_mode0");
        tick(1, 0, 2);
        chk("mode_hold_w0", 64'(o_txd), 64'h0001_0000);
        tick(1, 0, 2);
        chk("mode_hold_w1", 64'(o_txd), 64'h0002_0001);
        run_until_word(W_SOF, 20, "sof_fixed");
        tick(1, 0, 2);
        chk("fixed_w0", 64'({o_txd, o_tklsb}), 64'({FIXED, FIXED, 2'b00}));

        // Async reset mid-payload
        @(negedge clk);
        rstn = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_mode = 3'd0;
        #1;
        chk("async_reset_pins", 64'({o_txd, o_tklsb, o_tkmsb, o_busy, o_stop_ack}),
            64'({II, 2'b11, 2'b00, 1'b0, 1'b0}));
        chk("async_reset_fcnt", 64'(o_frame_cnt), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick(0, 0, 0);
        tick(1, 0, 0);
        run_until_word(W_EOF, 20, "eof_after_reset");
        chk("fcnt_after_reset", 64'(o_frame_cnt), 64'd1);

        // Random start/stop/mode traffic against the model
        for (int c = 0; c < 3000; c++) begin
            s = i_start;
            p = i_stop;
            if ($urandom_range(0, 29) == 0) s = ~s;
            if ($urandom_range(0, 49) == 0) p = ~p;
            tick(s, p, 3'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
